instruction_encoder: RTL and testbench
======================================

# instruction_encoder

Packs decoded RV32I instruction fields (format, register indices, function codes, full-width immediate) into 32-bit machine words and presents them, tagged with a byte address, to the instruction-memory loader. It is the encode direction of the core's immediate/format decode path and is used by the boot/self-test loader to build programs in instruction memory. It range-checks immediates, uses a one-entry registered output with valid/ready handshaking, and keeps an auto-incrementing word address.

## Interface
- ADDR_W, 10: width of byte address counter and out_addr
- ERRCNT_W, 8: width of saturating error counter
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input fields valid
- in_ready  out  1  block can accept fields
- in_format  in  3  0=R, 1=I(ALU), 2=S, 3=B, 4=LUI, 5=AUIPC, 6=JAL, 7=JALR
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R only)
- in_imm  in  32  full two's-complement immediate value (byte offset for B/J)
- addr_load  in  1  load address counter from addr_base
- addr_base  in  ADDR_W  new base byte address
- out_valid  out  1  encoded word valid
- out_ready  in  1  loader accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address of out_instr
- err  out  1  sticky: an input was rejected
- err_format  out  3  in_format of first rejected input since last clear
- err_count  out  ERRCNT_W  saturating count of rejected inputs
- err_clr  in  1  clear err, err_format, err_count

## Operation
- Opcodes: R 0110011, I 0010011, S 0100011, B 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111. JALR forces funct3=000.
- Packing per standard RV32I: I/JALR imm[11:0] at [31:20]; S imm[11:5] at [31:25], imm[4:0] at [11:7]; B imm[12|10:5] at [31:25], imm[4:1|11] at [11:7]; U imm[31:12] at [31:12]; J imm[20|10:1|11|19:12] at [31:12]. Unused fields are zero.
- Range rules: I/S/JALR −2048..2047; B −4096..4094, bit0=0; J −1048576..1048574, bit0=0; U imm[11:0]=0; R ignores in_imm.
- Accept = in_valid && in_ready. Valid accepted input: word is registered with current address; counter += 4 (wraps mod 2^ADDR_W).
- Rejected accepted input: no word produced, counter unchanged; err set; err_format captured only if err was 0; err_count increments, saturating at all-ones.
- addr_load: counter <= addr_base. If addr_load coincides with a valid accept, the word takes addr_base and counter <= addr_base+4.
- err_clr coinciding with a rejection: clear wins for err/err_format; err_count becomes 1.

## Timing
- Reset: out_valid=0, out_instr=0, out_addr=0, counter=0, err=0, err_format=0, err_count=0; in_ready=1 after reset.
- in_ready = !out_valid || out_ready (combinational; full throughput, one word/cycle).
- Latency: word visible on out_instr/out_addr one cycle after accept.
- out_valid held with stable out_instr/out_addr until out_ready; simultaneous drain and accept refills same cycle.
- Rejected input consumes one handshake but leaves out_valid unchanged if output already draining (out_valid falls if drained that cycle).
- Reset mid-transfer discards any pending word immediately.

## Configuration
- RANGE_CHECK_EN defined: range/alignment rules enforced as above.
- Undefined: no checks; immediates silently truncated to field bits; err, err_format, err_count tied to 0; err_clr ignored.

## Structure
- Shared package: format codes, opcode constants, immediate min/max constants.
- One sub-module natural: instr_pack (combinational field packing + range check, outputs word and reject flag); top holds output register, address counter, error logic.

## Test plan
- ADDI x1,x0,5 (fmt 1, rd=1, imm=5), addr_load base 0x100 -> out_instr 0x00500093, out_addr 0x100 one cycle later.
- SW x2,8(x1) then BEQ x1,x2,−4 back-to-back, out_ready=1 -> 0x0020A423 @0x000, 0xFE208EE3 @0x004.
- LUI x5,0x12345000 -> 0x123452B7; JAL x1,2048 -> 0x001000EF.
- I-type imm=2048 (check enabled) -> no out_valid, err=1, err_format=1, err_count=1, next valid word keeps prior address.
- out_ready=0 for 3 cycles with word pending -> in_ready=0, out_instr/out_addr stable; release -> drain and accept in same cycle.
- Counter at 0x3FC with ADDR_W=10, two words -> addresses 0x3FC then 0x000; assert rst mid-stream -> all outputs to reset values.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// Shared RV32I encode constants: format codes, opcodes and immediate limits.
// Immediate limits are used by the range check when RANGE_CHECK_EN is defined.
package instruction_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R     = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_LUI   = 3'd4,
        FMT_AUIPC = 3'd5,
        FMT_JAL   = 3'd6,
        FMT_JALR  = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;
    localparam int IMMJ_MIN  = -1048576;
    localparam int IMMJ_MAX  = 1048574;

    function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/instruction_encoder_pack.sv
// Combinational RV32I field packing plus immediate range/alignment check.
// The check (reject_c) is only built when RANGE_CHECK_EN is defined.
module instruction_encoder_pack
    import instruction_encoder_pkg::*;
(
    input  logic [2:0]  format,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr_c,
    output logic        reject_c
);

    always_comb begin
        instr_c = '0;
        case (fmt_e'(format))
            FMT_R:     instr_c = {funct7, rs2, rs1, funct3, rd, OP_R};
            FMT_I:     instr_c = {imm[11:0], rs1, funct3, rd, OP_I};
            FMT_S:     instr_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
            FMT_B:     instr_c = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
            FMT_LUI:   instr_c = {imm[31:12], rd, OP_LUI};
            FMT_AUIPC: instr_c = {imm[31:12], rd, OP_AUIPC};
            FMT_JAL:   instr_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            FMT_JALR:  instr_c = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            default:   instr_c = '0;
        endcase
    end

`ifdef RANGE_CHECK_EN
    always_comb begin
        reject_c = 1'b0;
        case (fmt_e'(format))
            FMT_R:               reject_c = 1'b0;
            FMT_I, FMT_S, FMT_JALR:
                                 reject_c = !in_range(imm, IMM12_MIN, IMM12_MAX);
            FMT_B:               reject_c = !in_range(imm, IMMB_MIN, IMMB_MAX) || imm[0];
            FMT_LUI, FMT_AUIPC:  reject_c = (imm[11:0] != 12'd0);
            FMT_JAL:             reject_c = !in_range(imm, IMMJ_MIN, IMMJ_MAX) || imm[0];
            default:             reject_c = 1'b0;
        endcase
    end
`else
    assign reject_c = 1'b0;
`endif

endmodule

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: one-entry registered output with valid/ready,
// auto-incrementing byte address, optional error tracking (RANGE_CHECK_EN).
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_format,
    input  logic [4:0]          in_rd,
    input  logic [4:0]          in_rs1,
    input  logic [4:0]          in_rs2,
    input  logic [2:0]          in_funct3,
    input  logic [6:0]          in_funct7,
    input  logic [31:0]         in_imm,
    input  logic                addr_load,
    input  logic [ADDR_W-1:0]   addr_base,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                err,
    output logic [2:0]          err_format,
    output logic [ERRCNT_W-1:0] err_count,
    input  logic                err_clr
);

    logic [31:0]       instr_c;
    logic              reject_c;
    logic              accept;
    logic              take;
    logic [ADDR_W-1:0] counter;
    logic [ADDR_W-1:0] word_addr;

    instruction_encoder_pack u_pack (
        .format   (in_format),
        .rd       (in_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .funct3   (in_funct3),
        .funct7   (in_funct7),
        .imm      (in_imm),
        .instr_c  (instr_c),
        .reject_c (reject_c)
    );

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign take      = accept && !reject_c;
    assign word_addr = addr_load ? addr_base : counter;

    // Output slot: refill wins over drain so back-to-back words stream at full rate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_instr <= instr_c;
            out_addr  <= word_addr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
        end else if (take) begin
            counter <= word_addr + ADDR_W'(4);
        end else if (addr_load) begin
            counter <= addr_base;
        end
    end

`ifdef RANGE_CHECK_EN
    logic rej;
    assign rej = accept && reject_c;

    // Clear beats a same-cycle rejection, except the count records that rejection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err        <= 1'b0;
            err_format <= '0;
            err_count  <= '0;
        end else if (err_clr) begin
            err        <= 1'b0;
            err_format <= '0;
            err_count  <= rej ? ERRCNT_W'(1) : '0;
        end else if (rej) begin
            err <= 1'b1;
            if (!err) begin
                err_format <= in_format;
            end
            if (err_count != '1) begin
                err_count <= err_count + ERRCNT_W'(1);
            end
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err        = 1'b0;
    assign err_format = '0;
    assign err_count  = '0;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed table-driven bench for instruction_encoder; error expectations
// follow RANGE_CHECK_EN.
module tb_instruction_encoder;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned ERRCNT_W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          in_format;
    logic [4:0]          in_rd, in_rs1, in_rs2;
    logic [2:0]          in_funct3;
    logic [6:0]          in_funct7;
    logic [31:0]         in_imm;
    logic                addr_load;
    logic [ADDR_W-1:0]   addr_base;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_instr;
    logic [ADDR_W-1:0]   out_addr;
    logic                err;
    logic [2:0]          err_format;
    logic [ERRCNT_W-1:0] err_count;
    logic                err_clr;

    instruction_encoder #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_format(in_format), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .addr_load(addr_load), .addr_base(addr_base),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .err_format(err_format), .err_count(err_count), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_format = v.fmt;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_imm    = v.imm;
        in_valid  = 1'b1;
    endtask

    task automatic drive_raw(input logic [2:0] fmt, input logic [31:0] imm);
        vec_t v;
        v = '{fmt, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imm, 32'd0};
        drive(v);
    endtask

    initial begin
        //         fmt   rd     rs1    rs2    f3    f7      imm              expected
        vecs[0]  = '{3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,           32'h00500093}; // ADDI x1,x0,5
        vecs[1]  = '{3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,           32'h0020A423}; // SW x2,8(x1)
        vecs[2]  = '{3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC,    32'hFE208EE3}; // BEQ -4
        vecs[3]  = '{3'd4, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000,    32'h123452B7}; // LUI
        vecs[4]  = '{3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,        32'h001000EF}; // JAL 2048
        vecs[5]  = '{3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF,    32'h402081B3}; // SUB
        vecs[6]  = '{3'd5, 5'd4, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF000,    32'hFFFFF217}; // AUIPC
        vecs[7]  = '{3'd7, 5'd1, 5'd5, 5'd0, 3'd7, 7'h00, 32'hFFFFFFFF,    32'hFFF280E7}; // JALR f3 forced
        vecs[8]  = '{3'd1, 5'd2, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFFF800,    32'h80010113}; // ADDI -2048
        vecs[9]  = '{3'd3, 5'd0, 5'd0, 5'd0, 3'd1, 7'h00, 32'd4094,        32'h7E001FE3}; // BNE +4094
        vecs[10] = '{3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00000,    32'h8000006F}; // JAL min
        vecs[11] = '{3'd2, 5'd0, 5'd0, 5'd0, 3'd2, 7'h00, 32'hFFFFFFFF,    32'hFE002FA3}; // SW -1

        rst = 1'b1; in_valid = 1'b0; in_format = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0; addr_load = 1'b0; addr_base = '0;
        out_ready = 1'b1; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_format", 32'(err_format), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Streaming table, first word loads base 0x100
        addr_base = 10'h100;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i]);
            addr_load = (i == 0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp);
            chk($sformatf("vec%0d_addr", i), 32'(out_addr), 32'h100 + 32'(4 * i));
        end
        addr_load = 1'b0;

        // Backpressure: word pending at 0x12C, next input held off
        drive(vecs[0]);
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready0", 32'(in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("stall%0d_instr", c), out_instr, vecs[11].exp);
            chk($sformatf("stall%0d_addr", c), 32'(out_addr), 32'h12C);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", 32'(out_valid), 32'd1);
        chk("release_instr", out_instr, vecs[0].exp);
        chk("release_addr", 32'(out_addr), 32'h130);

        // Out-of-range I immediate, then misaligned J, then a good word
        drive_raw(3'd1, 32'd2048);
        @(negedge clk);
`ifdef RANGE_CHECK_EN
        chk("rej_out_valid", 32'(out_valid), 32'd0);
        chk("rej_err", 32'(err), 32'd1);
        chk("rej_err_format", 32'(err_format), 32'd1);
        chk("rej_err_count", 32'(err_count), 32'd1);
`else
        chk("trunc_i_instr", out_instr, 32'h80000093);
        chk("trunc_i_addr", 32'(out_addr), 32'h134);
        chk("nochk_err", 32'(err), 32'd0);
`endif
        drive_raw(3'd6, 32'd3);
        in_rd = 5'd0;
        @(negedge clk);
`ifdef RANGE_CHECK_EN
        chk("rej2_err_format", 32'(err_format), 32'd1);
        chk("rej2_err_count", 32'(err_count), 32'd2);
`else
        chk("trunc_j_instr", out_instr, 32'h0020006F);
        chk("trunc_j_addr", 32'(out_addr), 32'h138);
`endif
        drive(vecs[1]);
        @(negedge clk);
        chk("after_rej_instr", out_instr, vecs[1].exp);
`ifdef RANGE_CHECK_EN
        chk("after_rej_addr", 32'(out_addr), 32'h134);
`else
        chk("after_rej_addr", 32'(out_addr), 32'h13C);
`endif

        // Clear coinciding with a misaligned branch
        drive_raw(3'd3, 32'd1);
        in_rd = 5'd0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
`ifdef RANGE_CHECK_EN
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_err_format", 32'(err_format), 32'd0);
        chk("clr_err_count", 32'(err_count), 32'd1);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
`else
        chk("trunc_b_instr", out_instr, 32'h00000063);
        chk("trunc_b_addr", 32'(out_addr), 32'h140);
        chk("nochk_err_count", 32'(err_count), 32'd0);
`endif

        // Address wrap from 0x3FC
        in_valid = 1'b0;
        addr_load = 1'b1;
        addr_base = 10'h3FC;
        @(negedge clk);
        addr_load = 1'b0;
        drive(vecs[3]);
        @(negedge clk);
        chk("wrap0_instr", out_instr, vecs[3].exp);
        chk("wrap0_addr", 32'(out_addr), 32'h3FC);
        drive(vecs[4]);
        @(negedge clk);
        chk("wrap1_instr", out_instr, vecs[4].exp);
        chk("wrap1_addr", 32'(out_addr), 32'h000);

        // Reset mid-stream discards the pending word at once
        drive(vecs[5]);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_instr", out_instr, 32'd0);
        chk("midrst_out_addr", 32'(out_addr), 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_instr", out_instr, vecs[5].exp);
        chk("postrst_addr", 32'(out_addr), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("final_drain_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
